comma_aligner: RTL and testbench
================================

Name: comma_aligner

Overview:
- RX word aligner that sits directly upstream of the 8b/10b decoder.
- Takes unaligned 10-bit words from the deserializer and finds the K28.x comma boundary.
- Presents symbol-aligned 10-bit codes on RxParallel_10 to the decoder.
- Uses the decoder's Decode_Error feedback to detect loss of alignment and re-acquire.

Parameters:
- LOCK_CNT, 3: consecutive commas at the same offset needed to declare sync (range 1..15).
- LOS_ERR_CNT, 4: consecutive bad events in SYNC before dropping to loss of sync (range 1..15).

Ports:
- BitCLK_10  in  1  word clock; all logic on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- RxRaw_10  in  10  unaligned word from the deserializer; bit0 is the earliest received bit; one new word every cycle.
- Decode_Error  in  1  Decode_Error from the downstream decoder.
- RxParallel_10  out  10  aligned code group; bit0 = a, bit9 = j (decoder bit order).
- Comma_Detect  out  1  the RxParallel_10 word carries a comma at bits[6:0].
- Aligned  out  1  the FSM is in SYNC.
- Align_Offset  out  4  locked bit offset, 0..9.

Behaviour:
- Reset (synchronous, Reset=1 at a clock edge):
  - prev_q=0, offset=0, state=LOS, lock_cnt=0, err_cnt=0.
  - All outputs 0.
  - Reset asserted mid-acquisition or in SYNC discards all state on that edge.
- Window:
  - win[19:0] = {RxRaw_10, prev_q}; prev_q <= RxRaw_10 every cycle.
  - Candidate at offset k (0..9) = win[k+9:k].
- Comma at offset k: win[k+6:k] == 7'h7C (K28 abcdeif RD-) or 7'h03 (RD+).
  - Evaluated for all 10 k each cycle.
  - If several offsets match, the lowest k wins (hit_k). hit = any match.
  - hit_here = comma at the current offset register.
- Output path, 1-cycle latency:
  - RxParallel_10 <= win[offset+9:offset].
  - Comma_Detect <= hit_here.
  - Both use the offset value present before the edge.
  - Data passes in every state; Aligned qualifies it.
- FSM states LOS, ACQ, SYNC:
  - LOS:
    - On hit: offset <= hit_k, lock_cnt <= 1, go to ACQ.
    - If LOCK_CNT==1, go to SYNC directly instead.
  - ACQ:
    - hit_here: lock_cnt++; when lock_cnt+1 == LOCK_CNT, go to SYNC.
    - hit at another offset (and not hit_here): offset <= hit_k, lock_cnt <= 1.
    - No comma: hold.
    - Decode_Error is ignored.
  - SYNC:
    - offset is frozen.
    - Bad event = Decode_Error, or a hit at any offset without hit_here. Coincident causes count once.
    - Bad event: err_cnt++.
    - hit_here with Decode_Error=0: err_cnt <= 0.
    - Otherwise: hold.
    - When err_cnt+1 reaches LOS_ERR_CNT on a bad event: go to LOS, err_cnt <= 0, lock_cnt <= 0. offset is retained.
- Aligned <= (next_state == SYNC), so it is registered in the same cycle as the transition.
- Align_Offset <= offset (registered copy).
- Offset change timing: an offset update at edge N affects RxParallel_10 from edge N+1.
- Counter widths: 4-bit counters, no wrap. Transitions fire before overflow.

Optional Feature:
- Macro ALIGN_REALIGN_CNT_EN.
- When defined:
  - Adds output Realign_Count [7:0]: a saturating count of SYNC->LOS transitions.
  - Resets to 0, sticks at 8'hFF.
- When undefined: the port and the counter are absent; all other behaviour is identical.

Decomposition:
- Package rx_pkg holds:
  - COMMA_P7 = 7'h7C and COMMA_N7 = 7'h03.
  - K28_5_RDN = 10'h17C and K28_5_RDP = 10'h283.
  - The align_state_t enum {LOS, ACQ, SYNC}.
- One sub-module, comma_search: purely combinational.
  - Inputs: the 20-bit window and the current offset.
  - Outputs: hit, hit_k (lowest), hit_here.
- FSM, counters and output registers live in comma_aligner.

Test Plan:
- Reset: assert Reset 2 cycles while driving random RxRaw_10 -> all outputs 0, state LOS; release, no commas -> Aligned stays 0.
- Acquisition: bitstream alternating K28.5 0x17C / 0x283 slipped by 3 bits, LOCK_CNT=3 -> Align_Offset=3, Aligned=1 after the 3rd comma; RxParallel_10 alternates 0x17C/0x283 with Comma_Detect=1.
- Offset change in ACQ: 2 commas at offset 3, then stream re-slipped to offset 7 -> offset reloads to 7, lock_cnt restarts, Aligned only after 3 commas at 7.
- Loss of sync: in SYNC at offset 3, hold Decode_Error=1 for 4 cycles (LOS_ERR_CNT=4) -> Aligned falls on the 4th edge. Repeat with 3 errors followed by a clean comma at offset 3 -> Aligned stays 1, err_cnt cleared.
- Misaligned comma: in SYNC, a single comma at offset 5 with no comma at offset 3 -> err_cnt=1, Align_Offset stays 3, Aligned stays 1.
- With ALIGN_REALIGN_CNT_EN: force 2 LOS events -> Realign_Count=2; force 300 LOS events -> Realign_Count=8'hFF.

Source files
------------

// File: rtl/rx_pkg.sv
// Shared constants and types for the RX comma aligner.
// Comma patterns are the 7-bit K28 "abcdeif" prefixes for both running disparities.
package rx_pkg;

  localparam int WORD_W = 10;
  localparam int WIN_W  = 2 * WORD_W;
  localparam int OFF_W  = 4;
  localparam int CNT_W  = 4;

  localparam logic [6:0] COMMA_P7 = 7'h7C;
  localparam logic [6:0] COMMA_N7 = 7'h03;

  localparam logic [WORD_W-1:0] K28_5_RDN = 10'h17C;
  localparam logic [WORD_W-1:0] K28_5_RDP = 10'h283;

  typedef enum logic [1:0] {
    LOS  = 2'd0,
    ACQ  = 2'd1,
    SYNC = 2'd2
  } align_state_t;

  function automatic logic is_comma7(input logic [6:0] seg);
    return (seg == COMMA_P7) || (seg == COMMA_N7);
  endfunction

endpackage

// File: rtl/comma_search.sv
// Combinational comma finder over the 20-bit two-word window.
// Reports any hit, the lowest matching offset, and whether the current offset matches.
module comma_search
  import rx_pkg::*;
(
  input  logic [WIN_W-1:0] win_i,
  input  logic [OFF_W-1:0] offset_i,
  output logic             hit_o,
  output logic [OFF_W-1:0] hit_k_o,
  output logic             hit_here_o
);

  logic [WORD_W-1:0] match;
  logic              unused_win;

  generate
    for (genvar gi = 0; gi < WORD_W; gi++) begin : g_off
      assign match[gi] = is_comma7(win_i[gi+6:gi]);
    end
  endgenerate

  // Scan from the top down so the lowest matching offset is the one left standing.
  always_comb begin
    hit_k_o = '0;
    for (int k = WORD_W - 1; k >= 0; k--) begin
      if (match[k]) begin
        hit_k_o = OFF_W'(k);
      end
    end
  end

  assign hit_o      = |match;
  assign hit_here_o = (offset_i < OFF_W'(WORD_W)) ? match[offset_i] : 1'b0;

  // The top bits of the window only ever feed candidate data, never a comma search.
  assign unused_win = ^win_i[WIN_W-1:16];

endmodule

// File: rtl/comma_aligner.sv
// 8b/10b word aligner: LOS/ACQ/SYNC lock FSM driven by comma hits and decoder errors.
// Define ALIGN_REALIGN_CNT_EN to add the saturating Realign_Count output.
module comma_aligner
  import rx_pkg::*;
#(
  parameter int LOCK_CNT    = 3,
  parameter int LOS_ERR_CNT = 4
) (
  input  logic              BitCLK_10,
  input  logic              Reset,
  input  logic [WORD_W-1:0] RxRaw_10,
  input  logic              Decode_Error,
  output logic [WORD_W-1:0] RxParallel_10,
  output logic              Comma_Detect,
  output logic              Aligned,
  output logic [OFF_W-1:0]  Align_Offset
`ifdef ALIGN_REALIGN_CNT_EN
  ,
  output logic [7:0]        Realign_Count
`endif
);

  localparam logic [CNT_W-1:0] LOCK_LIM = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] ERR_LIM  = CNT_W'(LOS_ERR_CNT);

  align_state_t      state_q, state_d;
  logic [WORD_W-1:0] prev_q;
  logic [OFF_W-1:0]  offset_q, offset_d;
  logic [CNT_W-1:0]  lock_cnt_q, lock_cnt_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic [WORD_W-1:0] rx_par_q;
  logic              comma_q;
  logic              aligned_q;
  logic [OFF_W-1:0]  align_off_q;
  logic              los_evt;

  logic [WIN_W-1:0]  win;
  logic [WORD_W-1:0] cand;
  logic              hit, hit_here, bad_evt;
  logic [OFF_W-1:0]  hit_k;

  assign win  = {RxRaw_10, prev_q};
  assign cand = WORD_W'(win >> offset_q);

  comma_search u_search (
    .win_i      (win),
    .offset_i   (offset_q),
    .hit_o      (hit),
    .hit_k_o    (hit_k),
    .hit_here_o (hit_here)
  );

  // A comma somewhere other than the locked offset is as suspicious as a decode error.
  assign bad_evt = Decode_Error || (hit && !hit_here);

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    lock_cnt_d = lock_cnt_q;
    err_cnt_d  = err_cnt_q;
    los_evt    = 1'b0;
    unique case (state_q)
      LOS: begin
        if (hit) begin
          offset_d   = hit_k;
          lock_cnt_d = 4'd1;
          state_d    = (LOCK_CNT == 1) ? SYNC : ACQ;
        end
      end
      ACQ: begin
        if (hit_here) begin
          lock_cnt_d = lock_cnt_q + 4'd1;
          if (lock_cnt_q + 4'd1 == LOCK_LIM) begin
            state_d = SYNC;
          end
        end else if (hit) begin
          offset_d   = hit_k;
          lock_cnt_d = 4'd1;
        end
      end
      SYNC: begin
        if (bad_evt) begin
          if (err_cnt_q + 4'd1 == ERR_LIM) begin
            state_d    = LOS;
            err_cnt_d  = '0;
            lock_cnt_d = '0;
            los_evt    = 1'b1;
          end else begin
            err_cnt_d = err_cnt_q + 4'd1;
          end
        end else if (hit_here) begin
          err_cnt_d = '0;
        end
      end
      default: state_d = LOS;
    endcase
  end

  always_ff @(posedge BitCLK_10) begin
    if (Reset) begin
      state_q     <= LOS;
      prev_q      <= '0;
      offset_q    <= '0;
      lock_cnt_q  <= '0;
      err_cnt_q   <= '0;
      rx_par_q    <= '0;
      comma_q     <= 1'b0;
      aligned_q   <= 1'b0;
      align_off_q <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= RxRaw_10;
      offset_q    <= offset_d;
      lock_cnt_q  <= lock_cnt_d;
      err_cnt_q   <= err_cnt_d;
      rx_par_q    <= cand;
      comma_q     <= hit_here;
      aligned_q   <= (state_d == SYNC);
      align_off_q <= offset_q;
    end
  end

  assign RxParallel_10 = rx_par_q;
  assign Comma_Detect  = comma_q;
  assign Aligned       = aligned_q;
  assign Align_Offset  = align_off_q;

`ifdef ALIGN_REALIGN_CNT_EN
  logic [7:0] realign_q;

  always_ff @(posedge BitCLK_10) begin
    if (Reset) begin
      realign_q <= '0;
    end else if (los_evt && (realign_q != 8'hFF)) begin
      realign_q <= realign_q + 8'd1;
    end
  end

  assign Realign_Count = realign_q;
`else
  logic unused_los_evt;
  assign unused_los_evt = los_evt;
`endif

endmodule

// File: tb/tb_comma_aligner.sv
// Scoreboard bench for comma_aligner: the driver pushes expected outputs per word,
// a negedge monitor pops and compares them one cycle later.
module tb_comma_aligner;
  import rx_pkg::*;

  localparam logic [9:0] KA  = K28_5_RDN;
  localparam logic [9:0] KB  = K28_5_RDP;
  localparam logic [9:0] FIL = 10'h2AA;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [9:0] raw  = '0;
  logic       derr = 1'b0;
  logic [9:0] rx_par;
  logic       comma_det;
  logic       aligned;
  logic [3:0] align_off;
`ifdef ALIGN_REALIGN_CNT_EN
  logic [7:0] realign_cnt;
`endif

  always #5 clk = ~clk;

  comma_aligner #(.LOCK_CNT(3), .LOS_ERR_CNT(4)) dut (
    .BitCLK_10     (clk),
    .Reset         (rst),
    .RxRaw_10      (raw),
    .Decode_Error  (derr),
    .RxParallel_10 (rx_par),
    .Comma_Detect  (comma_det),
    .Aligned       (aligned),
    .Align_Offset  (align_off)
`ifdef ALIGN_REALIGN_CNT_EN
    ,
    .Realign_Count (realign_cnt)
`endif
  );

  typedef struct {
    int    cyc;
    string tag;
    int    ed;
    int    ec;
    int    ea;
    int    eo;
    int    erc;
  } exp_t;

  exp_t       sb_q[$];
  int         cyc_cnt = 0;
  int         n_chk   = 0;
  int         n_err   = 0;
  logic [9:0] cur     = FIL;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input string tag, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s %s: got %0h expected %0h", tag, name, act, exp_v);
    end
  endtask

  task automatic push(input string tag, input int ed, input int ec, input int ea, input int eo, input int erc);
    exp_t e;
    e.cyc = cyc_cnt + 1;
    e.tag = tag;
    e.ed  = ed;
    e.ec  = ec;
    e.ea  = ea;
    e.eo  = eo;
    e.erc = erc;
    sb_q.push_back(e);
  endtask

  // Serialise the symbol stream slipped by o bits; the window this cycle holds `cur` at offset o.
  task automatic step(input logic [9:0] nxt, input int o, input logic de, input string tag,
                      input int ed, input int ec, input int ea, input int eo, input int erc = -1);
    logic [19:0] pair;
    @(posedge clk);
    #1;
    pair = {nxt, cur};
    rst  = 1'b0;
    raw  = 10'(pair >> (10 - o));
    derr = de;
    cur  = nxt;
    push(tag, ed, ec, ea, eo, erc);
  endtask

  task automatic rst_step(input string tag);
    @(posedge clk);
    #1;
    rst  = 1'b1;
    raw  = 10'($urandom);
    derr = 1'($urandom);
    cur  = FIL;
    push(tag, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].cyc < cyc_cnt) begin
      e = sb_q.pop_front();
      n_chk++;
      n_err++;
      $display("FAIL %s stale: got cycle %0d expected cycle %0d", e.tag, cyc_cnt, e.cyc);
    end
    if (sb_q.size() > 0 && sb_q[0].cyc == cyc_cnt) begin
      e = sb_q.pop_front();
      $display("txn %s cyc=%0d data=%h comma=%b aligned=%b off=%0d",
               e.tag, cyc_cnt, rx_par, comma_det, aligned, align_off);
      if (e.ed >= 0) chk("data",    e.tag, 32'(rx_par),    32'(e.ed));
      if (e.ec >= 0) chk("comma",   e.tag, 32'(comma_det), 32'(e.ec));
      if (e.ea >= 0) chk("aligned", e.tag, 32'(aligned),   32'(e.ea));
      if (e.eo >= 0) chk("offset",  e.tag, 32'(align_off), 32'(e.eo));
`ifdef ALIGN_REALIGN_CNT_EN
      if (e.erc >= 0) chk("realign", e.tag, 32'(realign_cnt), 32'(e.erc));
`endif
    end
  end

  initial begin
    // Reset with random input, then idle filler in LOS (offset 0 shows the previous word).
    rst_step("rst0");
    rst_step("rst1");
    step(FIL, 3, 0, "idle0", 0,      0, 0, 0);
    step(FIL, 3, 0, "idle1", 'h155,  0, 0, 0);
    step(FIL, 3, 0, "idle2", 'h155,  0, 0, 0);
    // Acquire K28.5 alternating at offset 3.
    step(KA,  3, 0, "acq_1", 'h155,  0, 0, 0);
    step(KB,  3, 0, "acq_2", -1,     0, 0, 0);
    step(KA,  3, 0, "acq_3", KB,     1, 0, 3);
    step(KB,  3, 0, "acq_4", KA,     1, 1, 3);
    step(KA,  3, 0, "sync_1", KB,    1, 1, 3);
    step(FIL, 3, 0, "sync_2", KA,    1, 1, 3);
    step(FIL, 3, 0, "sync_3", FIL,   0, 1, 3);
    // Four decode errors drop sync; offset is retained.
    step(FIL, 3, 1, "los_e1", FIL,   0, 1, 3);
    step(FIL, 3, 1, "los_e2", FIL,   0, 1, 3);
    step(FIL, 3, 1, "los_e3", FIL,   0, 1, 3);
    step(FIL, 3, 1, "los_e4", FIL,   0, 0, 3, 1);
    step(KA,  3, 0, "racq_1", FIL,   0, 0, 3);
    step(KB,  3, 0, "racq_2", KA,    1, 0, 3);
    step(KA,  3, 0, "racq_3", KB,    1, 0, 3);
    step(FIL, 3, 0, "racq_4", KA,    1, 1, 3);
    step(FIL, 3, 0, "racq_5", FIL,   0, 1, 3);
    // Three errors then a clean comma clears the error count.
    step(FIL, 3, 1, "err3_1", FIL,   0, 1, 3);
    step(FIL, 3, 1, "err3_2", FIL,   0, 1, 3);
    step(KA,  3, 1, "err3_3", FIL,   0, 1, 3);
    step(FIL, 3, 0, "clr",    KA,    1, 1, 3);
    step(FIL, 3, 1, "clr_e1", FIL,   0, 1, 3);
    step(FIL, 3, 1, "clr_e2", FIL,   0, 1, 3);
    step(FIL, 3, 1, "clr_e3", FIL,   0, 1, 3);
    step(KA,  3, 0, "clr2_a", FIL,   0, 1, 3);
    step(FIL, 3, 0, "clr2_b", KA,    1, 1, 3);
    step(FIL, 3, 0, "clr2_c", FIL,   0, 1, 3);
    // One comma at offset 5 counts as a single error; three more errors then lose sync.
    step(KA,  5, 0, "mis_1",  FIL,   0, 1, 3);
    step(FIL, 5, 0, "mis_2",  -1,    0, 1, 3);
    step(FIL, 5, 0, "mis_3",  -1,    0, 1, 3);
    step(FIL, 3, 0, "mis_4",  FIL,   0, 1, 3);
    step(FIL, 3, 1, "mis_e1", FIL,   0, 1, 3);
    step(FIL, 3, 1, "mis_e2", FIL,   0, 1, 3);
    step(FIL, 3, 1, "mis_e3", FIL,   0, 0, 3, 2);
    // Two commas at offset 3, then the stream re-slips to offset 7.
    step(KA,  3, 0, "oc_1",   FIL,   0, 0, 3);
    step(KB,  3, 0, "oc_2",   KA,    1, 0, 3);
    step(FIL, 3, 0, "oc_3",   KB,    1, 0, 3);
    step(FIL, 3, 0, "oc_4",   FIL,   0, 0, 3);
    step(KA,  7, 0, "oc_5",   FIL,   0, 0, 3);
    step(KB,  7, 0, "oc_6",   -1,    0, 0, 3);
    step(KA,  7, 0, "oc_7",   KB,    1, 0, 7);
    step(KB,  7, 0, "oc_8",   KA,    1, 1, 7);
    step(FIL, 7, 0, "oc_9",   KB,    1, 1, 7);
    step(FIL, 7, 0, "oc_10",  FIL,   0, 1, 7);
    // Reset while in SYNC discards everything.
    rst_step("rst2");
    step(FIL, 3, 0, "post_0", 0,     0, 0, 0);
    step(FIL, 3, 0, "post_1", 'h155, 0, 0, 0);
`ifdef ALIGN_REALIGN_CNT_EN
    for (int i = 0; i < 300; i++) begin
      step(KA,  3, 0, "rc_loop", -1, -1, -1, -1);
      step(KB,  3, 0, "rc_loop", -1, -1, -1, -1);
      step(KA,  3, 0, "rc_loop", -1, -1, -1, -1);
      step(KB,  3, 0, "rc_loop", -1, -1, -1, -1);
      for (int j = 0; j < 4; j++) begin
        step(FIL, 3, 1, "rc_loop", -1, -1, -1, -1);
      end
    end
    step(FIL, 3, 0, "rc_sat", -1, -1, 0, 3, 255);
`endif
    repeat (3) @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0 pending", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
